register_file_nr_nw_init: RTL and testbench

//  Flop-based multi-port SCM register file: N_WRITE write ports, N_READ registered read ports, byte enables.

---
 rtl/scm_rf_pkg.sv | 25 ++
 rtl/scm_rf_wr_merge.sv | 35 +++
 rtl/register_file_nr_nw_init.sv | 119 +++++++++++
 tb/tb_register_file_nr_nw_init.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scm_rf_pkg.sv
// Shared types and helpers for the N-read/N-write SCM register file.
// Optional write-to-read forwarding is selected by SCM_WRITE_BYPASS_EN.
package scm_rf_pkg;

  typedef enum logic {
    RF_INIT,
    RF_IDLE
  } rf_state_e;

  localparam int RF_MAX_DW = 1024;
  localparam int RF_MAX_BE = RF_MAX_DW / 8;

  // Callers truncate the widest mask down to their own word width.
  function automatic logic [RF_MAX_DW-1:0] be_to_mask(
    input logic [RF_MAX_BE-1:0] be
  );
    logic [RF_MAX_DW-1:0] m;
    m = '0;
    for (int b = 0; b < RF_MAX_BE; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/scm_rf_wr_merge.sv
// Per-word write merge: byte strobes plus next word value.
// Later ports override earlier ones per byte, earlier bytes survive.
module scm_rf_wr_merge
  import scm_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_WRITE    = 2
) (
  input  logic [N_WRITE-1:0]                    i_we,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    i_waddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    i_wdata,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]  i_be,
  input  logic [ADDR_WIDTH-1:0]                 i_idx,
  input  logic [DATA_WIDTH-1:0]                 i_cur,
  output logic [DATA_WIDTH/8-1:0]               o_strb,
  output logic [DATA_WIDTH-1:0]                 o_next
);

  logic [DATA_WIDTH-1:0] w_mask;

  always_comb begin
    o_strb = '0;
    o_next = i_cur;
    w_mask = '0;
    for (int p = 0; p < N_WRITE; p++) begin
      if (i_we[p] && (i_waddr[p] == i_idx)) begin
        w_mask = DATA_WIDTH'(be_to_mask(RF_MAX_BE'(i_be[p])));
        o_strb = o_strb | i_be[p];
        o_next = (o_next & ~w_mask) | (i_wdata[p] & w_mask);
      end
    end
  end

endmodule

// File: rtl/register_file_nr_nw_init.sv
// Flop-based N-read/N-write register file with post-reset zeroing sweep.
// Define SCM_WRITE_BYPASS_EN for write-first reads, else read-first.
module register_file_nr_nw_init
  import scm_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 InitBusy,
  input  logic [N_READ-1:0]                    ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]    ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]    ReadData,
  output logic [N_READ-1:0]                    ReadValid,
  input  logic [N_WRITE-1:0]                   WriteEnable,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]   WriteAddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]   WriteData,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0] WriteBe
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int NB        = DATA_WIDTH / 8;

  rf_state_e r_state;
  rf_state_e w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;

  logic [DATA_WIDTH-1:0] r_mem  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_next [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_rsrc [NUM_WORDS];
  logic [NB-1:0]         w_strb [NUM_WORDS];

  logic [N_READ-1:0][DATA_WIDTH-1:0] r_rdata;
  logic [N_READ-1:0]                 r_rvalid;

  logic               w_idle;
  logic               w_zero;
  logic [N_WRITE-1:0] w_we;

  assign w_idle = (r_state == RF_IDLE) && !rst;
  assign w_zero = (r_state == RF_INIT) && !rst;
  assign w_we   = WriteEnable & {N_WRITE{w_idle}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RF_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RF_INIT: if (r_cnt == '1) w_state_nxt = RF_IDLE;
      RF_IDLE: w_state_nxt = RF_IDLE;
      default: w_state_nxt = RF_INIT;
    endcase
  end

  always_comb begin
    InitBusy = (r_state == RF_INIT);
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    scm_rf_wr_merge #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .N_WRITE    (N_WRITE)
    ) u_merge (
      .i_we    (w_we),
      .i_waddr (WriteAddr),
      .i_wdata (WriteData),
      .i_be    (WriteBe),
      .i_idx   (ADDR_WIDTH'(g)),
      .i_cur   (r_mem[g]),
      .o_strb  (w_strb[g]),
      .o_next  (w_next[g])
    );

    always_ff @(posedge clk) begin
      if (w_zero && (r_cnt == ADDR_WIDTH'(g))) begin
        r_mem[g] <= '0;
      end else if (|w_strb[g]) begin
        r_mem[g] <= w_next[g];
      end
    end
  end

  // With no write hitting a word its merged value equals the stored one.
`ifdef SCM_WRITE_BYPASS_EN
  assign w_rsrc = w_next;
`else
  assign w_rsrc = r_mem;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      for (int r = 0; r < N_READ; r++) begin
        r_rvalid[r] <= w_idle && ReadEnable[r];
        if (w_idle && ReadEnable[r]) begin
          r_rdata[r] <= w_rsrc[ReadAddr[r]];
        end
      end
    end
  end

  assign ReadData  = r_rdata;
  assign ReadValid = r_rvalid;

endmodule

// File: tb/tb_register_file_nr_nw_init.sv
// Randomized bench for register_file_nr_nw_init with a byte-level model.
// Expectations follow SCM_WRITE_BYPASS_EN when it is defined.
module tb_register_file_nr_nw_init;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NWR = 2;
  localparam int NWD = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  logic InitBusy;
  logic [NR-1:0]            ReadEnable;
  logic [NR-1:0][AW-1:0]    ReadAddr;
  logic [NR-1:0][DW-1:0]    ReadData;
  logic [NR-1:0]            ReadValid;
  logic [NWR-1:0]           WriteEnable;
  logic [NWR-1:0][AW-1:0]   WriteAddr;
  logic [NWR-1:0][DW-1:0]   WriteData;
  logic [NWR-1:0][DW/8-1:0] WriteBe;

  register_file_nr_nw_init #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_READ     (NR),
    .N_WRITE    (NWR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .InitBusy    (InitBusy),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteBe     (WriteBe)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] m_mem [NWD];
  logic [DW-1:0] m_rd  [NR];
  logic [NR-1:0] m_rv;
  int            m_left;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = '0;
    WriteAddr   = '0;
    WriteData   = '0;
    WriteBe     = '0;
  endtask

  // One clock: model the edge from current inputs, then compare.
  task automatic step();
    logic [DW-1:0] nm [NWD];
    for (int i = 0; i < NWD; i++) nm[i] = m_mem[i];
    if (rst) begin
      m_left = NWD;
      m_rv = '0;
      for (int r = 0; r < NR; r++) m_rd[r] = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_rv = '0;
      if (m_left == 0) for (int i = 0; i < NWD; i++) m_mem[i] = '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (WriteEnable[p])
          for (int b = 0; b < DW / 8; b++)
            if (WriteBe[p][b])
              nm[WriteAddr[p]][8*b +: 8] = WriteData[p][8*b +: 8];
      for (int r = 0; r < NR; r++) begin
        m_rv[r] = ReadEnable[r];
        if (ReadEnable[r]) begin
`ifdef SCM_WRITE_BYPASS_EN
          m_rd[r] = nm[ReadAddr[r]];
`else
          m_rd[r] = m_mem[ReadAddr[r]];
`endif
        end
      end
      for (int i = 0; i < NWD; i++) m_mem[i] = nm[i];
    end
    @(posedge clk);
    #1;
    chk("busy", 64'(InitBusy), 64'(m_left != 0));
    for (int r = 0; r < NR; r++) begin
      chk("rvalid", 64'(ReadValid[r]), 64'(m_rv[r]));
      chk("rdata", 64'(ReadData[r]), 64'(m_rd[r]));
    end
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (InitBusy && cnt < 100) begin
      step();
      cnt++;
    end
    chk("init_len", 64'(cnt), 64'(NWD));
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [3:0] be);
    WriteEnable[p] = 1'b1;
    WriteAddr[p]   = a;
    WriteData[p]   = d;
    WriteBe[p]     = be;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] a);
    ReadEnable[r] = 1'b1;
    ReadAddr[r]   = a;
  endtask

  initial begin
    for (int i = 0; i < NWD; i++) m_mem[i] = 'x;
    for (int r = 0; r < NR; r++) m_rd[r] = '0;
    m_rv = '0;
    m_left = NWD;
    clr_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("rst_busy", 64'(InitBusy), 64'd1);
    chk("rst_rdata", 64'(ReadData[0]), 64'd0);
    rst = 1'b0;
    wait_init();

    for (int a = 0; a < NWD; a++) begin
      clr_in();
      rd(0, AW'(a));
      rd(1, AW'(NWD - 1 - a));
      step();
      chk("t1_zero", 64'(ReadData[0]), 64'd0);
    end

    clr_in();
    wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
    step();
    clr_in();
    rd(1, 5'd5);
    step();
    chk("t2_data", 64'(ReadData[1]), 64'hDEADBEEF);
    chk("t2_valid", 64'(ReadValid[1]), 64'd1);

    clr_in();
    wr(0, 5'd7, 32'h11111111, 4'hF);
    wr(1, 5'd7, 32'h22222222, 4'h3);
    step();
    clr_in();
    rd(0, 5'd7);
    step();
    chk("t3_merge", 64'(ReadData[0]), 64'h11112222);

    clr_in();
    wr(0, 5'd9, 32'hAAAAAAAA, 4'hF);
    step();
    clr_in();
    wr(1, 5'd9, 32'h55555555, 4'hF);
    rd(0, 5'd9);
    step();
`ifdef SCM_WRITE_BYPASS_EN
    chk("t4_bypass", 64'(ReadData[0]), 64'h55555555);
`else
    chk("t4_rdfirst", 64'(ReadData[0]), 64'hAAAAAAAA);
`endif

    clr_in();
    wr(0, 5'd3, 32'h12345678, 4'hF);
    wr(1, 5'd4, 32'h0BADF00D, 4'hF);
    step();
    clr_in();
    rd(0, 5'd3);
    rd(1, 5'd3);
    wr(1, 5'd4, 32'hCAFEF00D, 4'hF);
    step();
    chk("t6_rd0", 64'(ReadData[0]), 64'h12345678);
    chk("t6_rd1", 64'(ReadData[1]), 64'h12345678);
    clr_in();
    rd(0, 5'd4);
    rd(1, 5'd3);
    step();
    chk("t6_w4", 64'(ReadData[0]), 64'hCAFEF00D);
    chk("t6_w3", 64'(ReadData[1]), 64'h12345678);

    for (int n = 0; n < 400; n++) begin
      clr_in();
      for (int p = 0; p < NWR; p++) begin
        WriteEnable[p] = 1'($urandom);
        WriteAddr[p]   = AW'($urandom_range(0, 7));
        WriteData[p]   = $urandom;
        WriteBe[p]     = 4'($urandom);
      end
      for (int r = 0; r < NR; r++) begin
        ReadEnable[r] = 1'($urandom);
        ReadAddr[r]   = AW'($urandom_range(0, 7));
      end
      step();
    end

    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      clr_in();
      wr(0, AW'(n), $urandom, 4'hF);
      wr(1, 5'd9, 32'hFFFFFFFF, 4'hF);
      rd(0, AW'(n));
      step();
    end
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < NWD; n++) begin
      clr_in();
      wr(n % NWR, AW'(n), 32'hA5A5A5A5, 4'hF);
      rd(0, AW'(n));
      if (!InitBusy) break;
      step();
    end
    clr_in();
    chk("t5_done", 64'(InitBusy), 64'd0);
    for (int a = 0; a < NWD; a++) begin
      clr_in();
      rd(0, AW'(a));
      step();
    end
    clr_in();
    rd(1, 5'd9);
    step();
    chk("t5_w9", 64'(ReadData[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
